// File: rtl/range_frame_tx_if.sv
// Host and receiver-facing signal bundle for range_frame_tx.
// master: host/receiver side (drives samples, send, range_in).
// slave: the frame transmitter itself.
interface range_frame_tx_if #(
  parameter int WIDTH = 10
);
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             send;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] range_in;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             mismatch;
  logic             send_err;
  logic             busy;
  logic             full;
  logic             empty;

  modport master (
    output wr_en, wr_data, send, range_in,
    input  data_out, go, finish, result, result_valid, mismatch,
    input  send_err, busy, full, empty
  );

  modport slave (
    input  wr_en, wr_data, send, range_in,
    output data_out, go, finish, result, result_valid, mismatch,
    output send_err, busy, full, empty
  );
endinterface

// File: rtl/range_frame_tx.sv
// Frame transmitter: buffers samples, emits go/samples/finish, captures and checks range.
// Latency: go one cycle after send; result_valid N+3 cycles after send for an N-sample frame.
// Backpressure: pushes into a full FIFO are dropped unless a pop frees a slot that cycle.
module range_frame_tx #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input logic             clock,
  input logic             reset,
  range_frame_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [AW-1:0] A_ONE   = AW'(1);

  typedef enum logic [2:0] {IDLE, START, STREAM, FIN1, FIN2, GAP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, remain, remain_nxt;
  logic [WIDTH-1:0] head, min_r, max_r, data_r, result_r;
  logic             go_r, finish_r, rv_r, mis_r, serr_r, busy_r;
  logic             pop, push, load_first, serr_nxt, full_w;

  assign head   = mem[rd_ptr];
  assign full_w = (count == DEPTH_C);
  assign push   = bus.wr_en && (!full_w || pop);

  // Next-state: IDLE latches the frame length, START/STREAM pop one sample per cycle
  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    pop        = 1'b0;
    load_first = 1'b0;
    serr_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.send) begin
          if (count != '0) begin
            state_nxt  = START;
            pop        = 1'b1;
            load_first = 1'b1;
            remain_nxt = count - C_ONE;
          end else begin
            serr_nxt = 1'b1;
          end
        end
      end
      START, STREAM: begin
        if (remain == '0) begin
          state_nxt = FIN1;
        end else begin
          state_nxt  = STREAM;
          pop        = 1'b1;
          remain_nxt = remain - C_ONE;
        end
      end
      FIN1:    state_nxt = FIN2;
      FIN2:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, min/max trackers and registered outputs (decoded from the next state)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      remain   <= '0;
      min_r    <= '0;
      max_r    <= '0;
      data_r   <= '0;
      result_r <= '0;
      go_r     <= 1'b0;
      finish_r <= 1'b0;
      rv_r     <= 1'b0;
      mis_r    <= 1'b0;
      serr_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      remain   <= remain_nxt;
      go_r     <= (state_nxt == START);
      finish_r <= (state_nxt == FIN1) || (state_nxt == FIN2);
      busy_r   <= (state_nxt != IDLE);
      serr_r   <= serr_nxt;
      rv_r     <= (state == FIN2);
      mis_r    <= 1'b0;
      if (pop) begin
        data_r <= head;
        if (load_first) begin
          min_r <= head;
          max_r <= head;
        end else begin
          if (head < min_r) min_r <= head;
          if (head > max_r) max_r <= head;
        end
      end
      // finish is still high in FIN2, so range_in is stable here
      if (state == FIN2) begin
        result_r <= bus.range_in;
        mis_r    <= (bus.range_in != (max_r - min_r));
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + A_ONE;
      if (pop)  rd_ptr <= rd_ptr + A_ONE;
      if (push && !pop)      count <= count + C_ONE;
      else if (pop && !push) count <= count - C_ONE;
    end
  end

  // FIFO storage; contents are only meaningful where count says so
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.data_out     = data_r;
  assign bus.go           = go_r;
  assign bus.finish       = finish_r;
  assign bus.result       = result_r;
  assign bus.result_valid = rv_r;
  assign bus.mismatch     = mis_r;
  assign bus.send_err     = serr_r;
  assign bus.busy         = busy_r;
  assign bus.full         = full_w;
  assign bus.empty        = (count == '0);
endmodule

// File: tb/tb_range_frame_tx.sv
// Bench for range_frame_tx: directed scenarios plus randomized frames.
// Expected frames come from a queue model of the FIFO; expected range is max-min of the frame.
`timescale 1ns/1ps
module tb_range_frame_tx;
  localparam int W    = 10;
  localparam int D    = 16;
  localparam int KMAX = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;

  range_frame_tx_if #(.WIDTH(W)) bus ();

  range_frame_tx #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] frame[$];

  logic         o_go[KMAX], o_fin[KMAX], o_busy[KMAX];
  logic         o_rv[KMAX], o_mis[KMAX], o_err[KMAX];
  logic [W-1:0] o_dat[KMAX], o_res[KMAX];

  task automatic push(input logic [W-1:0] v);
    bus.wr_en   = 1'b1;
    bus.wr_data = v;
    @(negedge clock);
    bus.wr_en = 1'b0;
    if (mq.size() < D) mq.push_back(v);
  endtask

  // send latches every queued sample into one frame
  task automatic take_frame();
    frame = mq;
    mq.delete();
  endtask

  function automatic logic [W-1:0] model_range();
    logic [W-1:0] mn, mx;
    mn = frame[0];
    mx = frame[0];
    foreach (frame[i]) begin
      if (frame[i] < mn) mn = frame[i];
      if (frame[i] > mx) mx = frame[i];
    end
    return mx - mn;
  endfunction

  // Pulse send for one cycle and record outputs for cycles t+1..t+ncyc.
  // Optionally push push_v during cycle t+push_k.
  task automatic capture(input int ncyc, input int push_k, input logic [W-1:0] push_v);
    bus.send = 1'b1;
    @(negedge clock);
    bus.send = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      o_go[k] = bus.go;   o_fin[k] = bus.finish; o_busy[k] = bus.busy;
      o_rv[k] = bus.result_valid; o_mis[k] = bus.mismatch; o_err[k] = bus.send_err;
      o_dat[k] = bus.data_out; o_res[k] = bus.result;
      if (k == push_k) begin
        bus.wr_en = 1'b1; bus.wr_data = push_v;
        if (mq.size() < D) mq.push_back(push_v);
      end else begin
        bus.wr_en = 1'b0;
      end
      @(negedge clock);
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++;
    if ({bus.data_out, bus.result} !== '0) begin
      n_fail++; $display("FAIL reset_data got %0h/%0h need 0/0", bus.data_out, bus.result);
    end
    n_checks++;
    if ({bus.go, bus.finish, bus.result_valid, bus.mismatch, bus.send_err, bus.busy, bus.full,
         bus.empty} !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL reset_flags got %b%b%b%b%b%b%b%b need 00000001", bus.go, bus.finish,
               bus.result_valid, bus.mismatch, bus.send_err, bus.busy, bus.full, bus.empty);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_send_empty();
    capture(4, 0, '0);
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (o_err[k] !== (k == 1)) begin
        n_fail++; $display("FAIL send_err k=%0d got %b need %b", k, o_err[k], (k == 1));
      end
      n_checks++;
      if ({o_go[k], o_busy[k]} !== 2'b00) begin
        n_fail++; $display("FAIL empty_go_busy k=%0d got %b%b need 00", k, o_go[k], o_busy[k]);
      end
    end
  endtask

  task automatic test_basic();
    int n;
    push(10'd100); push(10'd30); push(10'd700); push(10'd250);
    take_frame();
    n = frame.size();
    bus.range_in = 10'd670;
    capture(n + 5, 0, '0);
    for (int k = 1; k <= n + 4; k++) begin
      n_checks++;
      if ({o_go[k], o_fin[k], o_busy[k], o_rv[k]} !==
          {k == 1, k == n + 1 || k == n + 2, k <= n + 3, k == n + 3}) begin
        n_fail++;
        $display("FAIL basic_ctl k=%0d got go%b fin%b busy%b rv%b", k, o_go[k], o_fin[k],
                 o_busy[k], o_rv[k]);
      end
      if (k <= n + 2) begin
        n_checks++;
        if (o_dat[k] !== frame[(k <= n) ? k - 1 : n - 1]) begin
          n_fail++; $display("FAIL basic_data k=%0d got %0d need %0d", k, o_dat[k],
                             frame[(k <= n) ? k - 1 : n - 1]);
        end
      end
    end
    n_checks++;
    if (o_res[n + 3] !== 10'd670 || o_mis[n + 3] !== 1'b0) begin
      n_fail++; $display("FAIL basic_result got %0d mis %b need 670 mis 0", o_res[n + 3],
                         o_mis[n + 3]);
    end
  endtask

  task automatic test_single();
    push(10'd512);
    take_frame();
    bus.range_in = '0;
    capture(6, 0, '0);
    n_checks++;
    if (o_go[1] !== 1'b1 || o_dat[1] !== 10'd512) begin
      n_fail++; $display("FAIL single_go got go%b data %0d need go1 data 512", o_go[1], o_dat[1]);
    end
    n_checks++;
    if ({o_fin[1], o_fin[2], o_fin[3], o_fin[4]} !== 4'b0110) begin
      n_fail++; $display("FAIL single_fin got %b%b%b%b need 0110", o_fin[1], o_fin[2], o_fin[3],
                         o_fin[4]);
    end
    n_checks++;
    if (o_rv[4] !== 1'b1 || o_res[4] !== '0 || o_mis[4] !== 1'b0 || o_busy[5] !== 1'b0) begin
      n_fail++; $display("FAIL single_result got rv%b res %0d mis%b busy%b need rv1 res 0 mis0 busy0",
                         o_rv[4], o_res[4], o_mis[4], o_busy[5]);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < D + 2; i++) begin
      push(W'($urandom_range(0, 1023)));
      if (i == D - 2 || i == D - 1 || i == D + 1) begin
        n_checks++;
        if (bus.full !== (i >= D - 1)) begin
          n_fail++; $display("FAIL full_flag push=%0d got %b need %b", i + 1, bus.full, (i >= D - 1));
        end
      end
    end
    take_frame();
    bus.range_in = model_range();
    capture(D + 5, 0, '0);
    for (int k = 1; k <= D + 1; k++) begin
      n_checks++;
      if (k <= D && o_dat[k] !== frame[k - 1]) begin
        n_fail++; $display("FAIL full_data k=%0d got %0d need %0d", k, o_dat[k], frame[k - 1]);
      end else if (o_fin[k] !== (k == D + 1)) begin
        n_fail++; $display("FAIL full_len k=%0d fin got %b need %b", k, o_fin[k], (k == D + 1));
      end
    end
    n_checks++;
    if (bus.empty !== 1'b1 || o_mis[D + 3] !== 1'b0) begin
      n_fail++; $display("FAIL full_after empty %b mis %b need 1 0", bus.empty, o_mis[D + 3]);
    end
  endtask

  task automatic test_push_during_stream();
    push(10'd5); push(10'd9);
    take_frame();
    bus.range_in = 10'd3;
    capture(7, 2, 10'd1);
    n_checks++;
    if (o_rv[5] !== 1'b1 || o_res[5] !== 10'd3 || o_mis[5] !== 1'b1) begin
      n_fail++; $display("FAIL forced_range got rv%b res %0d mis%b need rv1 res 3 mis1",
                         o_rv[5], o_res[5], o_mis[5]);
    end
    take_frame();
    bus.range_in = model_range();
    capture(6, 0, '0);
    n_checks++;
    if (o_go[1] !== 1'b1 || o_dat[1] !== 10'd1 || o_fin[2] !== 1'b1) begin
      n_fail++; $display("FAIL late_push_frame got go%b data %0d fin%b need go1 data 1 fin1",
                         o_go[1], o_dat[1], o_fin[2]);
    end
    n_checks++;
    if (o_res[4] !== '0 || o_mis[4] !== 1'b0) begin
      n_fail++; $display("FAIL late_push_result got %0d mis%b need 0 mis0", o_res[4], o_mis[4]);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      int n;
      logic bad;
      logic [W-1:0] exp_r, rin;
      n = $urandom_range(1, D);
      for (int i = 0; i < n; i++) push(W'($urandom_range(0, 1023)));
      take_frame();
      exp_r = model_range();
      bad   = ($urandom_range(0, 3) == 0);
      rin   = bad ? exp_r + W'($urandom_range(1, 1023)) : exp_r;
      bus.range_in = rin;
      capture(n + 5, 0, '0);
      for (int k = 1; k <= n + 4; k++) begin
        n_checks++;
        if (o_go[k] && o_fin[k]) begin
          n_fail++; $display("FAIL rand_go_fin f=%0d k=%0d both high", f, k);
        end
        if (k <= n) begin
          n_checks++;
          if (o_dat[k] !== frame[k - 1]) begin
            n_fail++; $display("FAIL rand_data f=%0d k=%0d got %0d need %0d", f, k, o_dat[k],
                               frame[k - 1]);
          end
        end
        n_checks++;
        if (o_mis[k] !== (bad && k == n + 3)) begin
          n_fail++; $display("FAIL rand_mis f=%0d k=%0d got %b need %b (exp range %0d)", f, k,
                             o_mis[k], (bad && k == n + 3), exp_r);
        end
      end
      n_checks++;
      if (o_rv[n + 3] !== 1'b1 || o_res[n + 3] !== rin || o_busy[n + 4] !== 1'b0) begin
        n_fail++; $display("FAIL rand_result f=%0d got rv%b res %0d busy%b need rv1 res %0d busy0",
                           f, o_rv[n + 3], o_res[n + 3], o_busy[n + 4], rin);
      end
    end
  endtask

  task automatic test_mid_reset();
    push(10'd40); push(10'd900); push(10'd7);
    bus.send = 1'b1;
    @(negedge clock);
    bus.send = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.go, bus.finish, bus.busy, bus.empty} !== 4'b0001 || bus.result !== '0 ||
        bus.data_out !== '0) begin
      n_fail++; $display("FAIL mid_reset got go%b fin%b busy%b empty%b res %0d data %0d",
                         bus.go, bus.finish, bus.busy, bus.empty, bus.result, bus.data_out);
    end
    mq.delete();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    push(10'd8);
    take_frame();
    bus.range_in = model_range();
    capture(6, 0, '0);
    n_checks++;
    if (o_go[1] !== 1'b1 || o_dat[1] !== 10'd8 || o_rv[4] !== 1'b1 || o_res[4] !== '0 ||
        o_mis[4] !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_frame got go%b data %0d rv%b res %0d mis%b",
                         o_go[1], o_dat[1], o_rv[4], o_res[4], o_mis[4]);
    end
  endtask

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.send     = 1'b0;
    bus.range_in = '0;
    test_reset();
    test_send_empty();
    test_basic();
    test_single();
    test_full();
    test_push_during_stream();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/range_frame_tx.md
Name: range_frame_tx

Overview:
- Transmit end of the go/finish range-measurement interface: drives sample frames into a range-finder block and collects its range result.
- Host pushes WIDTH-bit samples into an internal FIFO, then pulses send; the block emits one framed burst (go, samples, finish) and captures the returned range.
- Computes its own expected range in parallel and flags any mismatch.
- Used as an on-chip self-test stimulus source and as the bench driver for range-finder blocks.

Parameters:
WIDTH, 10, sample and range width in bits.
DEPTH, 16, FIFO entries; power of two, 2..256.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
wr_en  in  1  push wr_data into the FIFO this cycle.
wr_data  in  WIDTH  sample to push.
send  in  1  start-frame request, level-sampled each cycle.
data_out  out  WIDTH  sample to the receiver.
go  out  1  frame start to the receiver.
finish  out  1  frame end to the receiver.
range_in  in  WIDTH  range returned by the receiver.
result  out  WIDTH  captured range, held until the next capture.
result_valid  out  1  one-cycle pulse when result updates.
mismatch  out  1  valid with result_valid: result differs from the expected range.
send_err  out  1  one-cycle pulse: send seen while the FIFO was empty.
busy  out  1  frame in progress (state other than IDLE).
full  out  1  FIFO count == DEPTH.
empty  out  1  FIFO count == 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset low, any cycle, including mid-frame):
  - state -> IDLE; FIFO flushed; frame counter, min and max trackers cleared.
  - Outputs: data_out=0, go=0, finish=0, result=0, result_valid=0, mismatch=0, send_err=0, busy=0, full=0, empty=1.
- FIFO:
  - A push is accepted when wr_en=1 and (!full or a pop occurs in the same cycle). A push while full with no pop is dropped.
  - Push and pop in the same cycle leave the count unchanged.
  - Pushes are legal while busy; they do not join the current frame.
- State machine, all outputs registered:
  - IDLE:
    - send=1, count>0: latch N=count (1..DEPTH); go to START.
    - send=1, count==0: pulse send_err; stay in IDLE.
    - go=0, finish=0.
  - START, 1 cycle:
    - go=1, finish=0, data_out = popped sample s0.
    - Load min=max=s0.
    - N==1 -> FIN1; otherwise -> STREAM.
  - STREAM, N-1 cycles:
    - go=0, finish=0, data_out = next popped sample.
    - Unsigned update: min = min(min, s); max = max(max, s).
    - After the last sample -> FIN1.
  - FIN1: finish=1, go=0, data_out holds its last value.
  - FIN2: finish=1 still asserted, so the receiver holds its result.
    - Capture result <= range_in at the end of this cycle.
    - result_valid and mismatch are asserted the following cycle.
  - GAP, 1 cycle: go=0, finish=0, so the receiver returns to its idle/clear state; -> IDLE.
    - GAP is mandatory: a receiver re-started directly out of its finish state drops the first sample.
- Frame timing: send sampled in cycle t -> go high in cycle t+1 -> finish high in t+1+N and t+2+N -> result_valid in t+3+N -> busy low in t+4+N.
- send is ignored while busy.
- Expected range = max - min, WIDTH bits, unsigned, never negative.
- mismatch = (range_in captured != expected range); mismatch is 0 whenever result_valid is 0.
- go and finish are never high in the same cycle.

Test Plan:
- Reset released, FIFO empty, send=1 for 1 cycle -> send_err pulses once; go stays 0; busy stays 0.
- Push 100, 30, 700, 250; send; compliant receiver attached -> go with data_out=100, then 30, 700, 250; finish high 2 cycles; result=670, result_valid pulse, mismatch=0; busy low at t+8.
- Push a single sample 512; send -> go with 512, finish the next cycle; result=0, mismatch=0.
- Push DEPTH+2 samples -> full=1 after DEPTH pushes, last 2 dropped; send -> frame of exactly DEPTH samples; empty=1 afterwards.
- Push 5, 9; send; push 1 during STREAM; range_in forced to 3 -> result=3, mismatch=1. Second send -> frame contains only sample 1.
- reset low during STREAM -> go, finish, busy, result drop to 0 immediately; FIFO empty. After release, push 8; send -> normal frame, result=0.
